// File: rtl/vga_pixel_fetch.sv
// Scan-position to frame-memory address converter with sync/blank alignment delay line.
// Optional 2x pixel doubling is enabled by defining PIXEL_DOUBLE_EN.
module vga_pixel_fetch #(
  parameter int IMG_W   = 250,
  parameter int IMG_H   = 250,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              video_on_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic [9:0]        x_out,
  output logic [9:0]        y_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              video_on_out,
  output logic              in_image_out,
  output logic              frame_done
);

`ifdef PIXEL_DOUBLE_EN
  localparam int SCALE = 2;
`else
  localparam int SCALE = 1;
`endif

  localparam logic [9:0]        REG_X    = 10'(IMG_W * SCALE);
  localparam logic [9:0]        REG_Y    = 10'(IMG_H * SCALE);
  localparam logic [9:0]        LAST_X   = 10'(IMG_W * SCALE - 1);
  localparam logic [9:0]        LAST_Y   = 10'(IMG_H * SCALE - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  typedef enum logic {WAIT_FRAME, RUN} state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       img;
  } tap_t;

  localparam tap_t TAP_RST = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, von: 1'b0, img: 1'b0};

  state_t            state_reg;
  logic [ADDR_W-1:0] row_base_reg;
  logic [ADDR_W-1:0] col_reg;
  logic [9:0]        x_reg;
  logic [9:0]        y_reg;
  logic              hs_reg;
  logic              vs_reg;
  logic              von_reg;

  logic              in_region;
  logic              frame_start;
  logic              active;
  logic [ADDR_W-1:0] base_eff;
  logic [ADDR_W-1:0] col_eff;

  assign in_region   = (x < REG_X) && (y < REG_Y);
  assign frame_start = (x == 10'd0) && (y == 10'd0);
  // The frame-start pixel is fetched even while still waiting for the first frame.
  assign active      = (state_reg == RUN) || frame_start;
  assign base_eff    = frame_start ? '0 : row_base_reg;
  assign col_eff     = frame_start ? '0 : col_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= WAIT_FRAME;
      row_base_reg <= '0;
      col_reg      <= '0;
      mem_addr     <= '0;
      mem_rd_en    <= 1'b0;
      frame_done   <= 1'b0;
      x_reg        <= 10'd0;
      y_reg        <= 10'd0;
      hs_reg       <= 1'b1;
      vs_reg       <= 1'b1;
      von_reg      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      x_reg      <= x;
      y_reg      <= y;
      hs_reg     <= hsync_in;
      vs_reg     <= vsync_in;
      von_reg    <= video_on_in & active;
      if (frame_start)
        state_reg <= RUN;
      if (active && in_region) begin
        mem_addr  <= base_eff + col_eff;
        mem_rd_en <= 1'b1;
        if (x == LAST_X) begin
          col_reg <= '0;
          if (y == LAST_Y) begin
            row_base_reg <= '0;
            frame_done   <= 1'b1;
          end else begin
`ifdef PIXEL_DOUBLE_EN
            row_base_reg <= y[0] ? base_eff + ROW_STEP : base_eff;
`else
            row_base_reg <= base_eff + ROW_STEP;
`endif
          end
        end else begin
`ifdef PIXEL_DOUBLE_EN
          col_reg      <= x[0] ? col_eff + ONE : col_eff;
`else
          col_reg      <= col_eff + ONE;
`endif
          row_base_reg <= base_eff;
        end
      end else begin
        mem_rd_en <= 1'b0;
      end
    end
  end

  // Stage 0 sits alongside the address register; MEM_LAT further stages cover the RAM read.
  tap_t tap0;
  tap_t line_reg [MEM_LAT];

  assign tap0 = '{x: x_reg, y: y_reg, hs: hs_reg, vs: vs_reg, von: von_reg, img: mem_rd_en};

  genvar gi;
  generate
    for (gi = 0; gi < MEM_LAT; gi++) begin : g_dly
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (!rst_n) line_reg[gi] <= TAP_RST;
          else        line_reg[gi] <= tap0;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (!rst_n) line_reg[gi] <= TAP_RST;
          else        line_reg[gi] <= line_reg[gi-1];
        end
      end
    end
  endgenerate

  assign x_out        = line_reg[MEM_LAT-1].x;
  assign y_out        = line_reg[MEM_LAT-1].y;
  assign hsync_out    = line_reg[MEM_LAT-1].hs;
  assign vsync_out    = line_reg[MEM_LAT-1].vs;
  assign video_on_out = line_reg[MEM_LAT-1].von;
  assign in_image_out = line_reg[MEM_LAT-1].img;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Raster-scan bench for vga_pixel_fetch: randomized syncs/blanking checked against an arithmetic address model.
module tb_vga_pixel_fetch;
`ifdef PIXEL_DOUBLE_EN
  localparam int S = 2;
  localparam int IMG_W = 40;
  localparam int IMG_H = 40;
`else
  localparam int S = 1;
  localparam int IMG_W = 250;
  localparam int IMG_H = 250;
`endif
  localparam int ADDR_W  = 16;
  localparam int MEM_LAT = 1;
  localparam int RW = IMG_W * S;
  localparam int RH = IMG_H * S;

  logic              clk;
  logic              rst_n;
  logic [9:0]        x;
  logic [9:0]        y;
  logic              hsync_in;
  logic              vsync_in;
  logic              video_on_in;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [9:0]        x_out;
  logic [9:0]        y_out;
  logic              hsync_out;
  logic              vsync_out;
  logic              video_on_out;
  logic              in_image_out;
  logic              frame_done;

  vga_pixel_fetch #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .video_on_in(video_on_in),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .x_out(x_out), .y_out(y_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .video_on_out(video_on_out),
    .in_image_out(in_image_out), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int addr;
    bit en;
    bit fd;
    int xo;
    int yo;
    bit hs;
    bit vs;
    bit von;
  } rec_t;

  rec_t hist [MEM_LAT+1];
  bit   started;
  int   last_addr;
  int   tests;
  int   fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock: drive inputs, advance the model, then compare at the falling edge.
  task automatic cyc(input int xi, input int yi, input bit hs, input bit vs, input bit von,
                     input bit rst = 1'b0);
    rec_t r;
    bit   st_now;
    bit   inreg;
    x           = 10'(xi);
    y           = 10'(yi);
    hsync_in    = hs;
    vsync_in    = vs;
    video_on_in = von;
    rst_n       = ~rst;
    if (rst) begin
      r = '{addr: 0, en: 0, fd: 0, xo: 0, yo: 0, hs: 1, vs: 1, von: 0};
      for (int i = 0; i <= MEM_LAT; i++) hist[i] = r;
      started   = 1'b0;
      last_addr = 0;
    end else begin
      st_now = started || (xi == 0 && yi == 0);
      inreg  = (xi < RW) && (yi < RH);
      r.xo = xi; r.yo = yi; r.hs = hs; r.vs = vs; r.von = von && st_now;
      if (st_now && inreg) begin
        r.addr = (yi / S) * IMG_W + xi / S;
        r.en   = 1'b1;
        r.fd   = (xi == RW - 1) && (yi == RH - 1);
      end else begin
        r.addr = last_addr;
        r.en   = 1'b0;
        r.fd   = 1'b0;
      end
      last_addr = r.addr;
      started   = st_now;
      for (int i = MEM_LAT; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = r;
    end
    @(posedge clk);
    @(negedge clk);
    chk("mem_addr",     32'(mem_addr),     32'(hist[0].addr));
    chk("mem_rd_en",    32'(mem_rd_en),    32'(hist[0].en));
    chk("frame_done",   32'(frame_done),   32'(hist[0].fd));
    chk("x_out",        32'(x_out),        32'(hist[MEM_LAT].xo));
    chk("y_out",        32'(y_out),        32'(hist[MEM_LAT].yo));
    chk("hsync_out",    32'(hsync_out),    32'(hist[MEM_LAT].hs));
    chk("vsync_out",    32'(vsync_out),    32'(hist[MEM_LAT].vs));
    chk("video_on_out", 32'(video_on_out), 32'(hist[MEM_LAT].von));
    chk("in_image_out", 32'(in_image_out), 32'(hist[MEM_LAT].en));
  endtask

  task automatic scan(input int yi, input int x0, input int x1);
    for (int xi = x0; xi <= x1; xi++) cyc(xi, yi, rb(), rb(), rb());
  endtask

  task automatic blank(input int yi);
    int n;
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) cyc(int'($urandom_range(RW, 1023)), yi, rb(), rb(), 1'b0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    x = '0; y = '0; hsync_in = 1'b1; vsync_in = 1'b1; video_on_in = 1'b0; rst_n = 1'b0;

    repeat (3) cyc(0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_hsync", 32'(hsync_out), 32'd1);
    chk("rst_vsync", 32'(vsync_out), 32'd1);

    // In-region pixels before any frame start must not be fetched.
    repeat (4) cyc(5, 5, rb(), rb(), 1'b1);
    chk("preframe_rd_en", 32'(mem_rd_en), 32'd0);
    chk("preframe_video", 32'(video_on_out), 32'd0);

    cyc(0, 0, 1'b1, 1'b1, 1'b1);
    chk("first_addr", 32'(mem_addr), 32'd0);
    chk("first_rd_en", 32'(mem_rd_en), 32'd1);
    cyc(1, 0, 1'b1, 1'b1, 1'b1);
    chk("first_x_out", 32'(x_out), 32'd0);
    chk("first_in_image", 32'(in_image_out), 32'd1);
    scan(0, 2, RW - 1);
    chk("row0_end", 32'(mem_addr), 32'(IMG_W - 1));
    blank(0);
    cyc(0, 1, 1'b1, 1'b1, 1'b1);
    chk("row1_start", 32'(mem_addr), 32'((1 / S) * IMG_W));
    scan(1, 1, RW - 1);
    blank(1);
    for (int r = 2; r < RH - 1; r++) begin
      scan(r, 0, RW - 1);
      blank(r);
    end
    scan(RH - 1, 0, RW - 1);
    chk("last_addr", 32'(mem_addr), 32'(IMG_W * IMG_H - 1));
    chk("frame_done_hi", 32'(frame_done), 32'd1);
    cyc(RW + 10, RH - 1, 1'b1, 1'b1, 1'b0);
    chk("frame_done_lo", 32'(frame_done), 32'd0);
    chk("post_frame_hold", 32'(mem_addr), 32'(IMG_W * IMG_H - 1));

    cyc(0, 0, 1'b1, 1'b1, 1'b1);
    chk("frame1_start", 32'(mem_addr), 32'd0);
    scan(0, 1, 9);
    cyc(300, 10, 1'b1, 1'b1, 1'b0);
    chk("oor_rd_en", 32'(mem_rd_en), 32'd0);
    chk("oor_hold", 32'(mem_addr), 32'(9 / S));
    cyc(301, 10, 1'b1, 1'b1, 1'b0);
    chk("oor_in_image", 32'(in_image_out), 32'd0);

    // hsync falling edge must reach the output two cycles later.
    cyc(10, 0, 1'b1, 1'b1, 1'b1);
    cyc(11, 0, 1'b0, 1'b1, 1'b1);
    chk("hsync_t1", 32'(hsync_out), 32'd1);
    cyc(12, 0, 1'b0, 1'b1, 1'b1);
    chk("hsync_t2", 32'(hsync_out), 32'd0);
    scan(0, 13, RW - 1);
    blank(0);
    scan(1, 0, 4);

    // Frame start mid-frame resynchronises the counters.
    cyc(0, 0, 1'b1, 1'b1, 1'b1);
    chk("resync_addr", 32'(mem_addr), 32'd0);
    cyc(1, 0, 1'b1, 1'b1, 1'b1);
    chk("resync_next", 32'(mem_addr), 32'(1 / S));
    scan(0, 2, 5);

    cyc(6, 0, rb(), rb(), 1'b1, 1'b1);
    chk("midrst_addr", 32'(mem_addr), 32'd0);
    chk("midrst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("midrst_x_out", 32'(x_out), 32'd0);
    chk("midrst_video", 32'(video_on_out), 32'd0);
    chk("midrst_hsync", 32'(hsync_out), 32'd1);
    repeat (3) cyc(5, 5, rb(), rb(), 1'b1);
    chk("postrst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("postrst_video", 32'(video_on_out), 32'd0);

    cyc(0, 0, 1'b1, 1'b1, 1'b1);
    chk("postrst_start", 32'(mem_addr), 32'd0);
    for (int r = 0; r < 4; r++) begin
      scan(r, (r == 0) ? 1 : 0, RW - 1);
      blank(r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
